// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux. It issues a one-hot grant and a matching select,
// and caps each owner's tenure at HOLD_MAX cycles while other requesters are waiting.
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       preempt
);
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e              state_q, state_d;
    logic [1:0]          last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [3:0]          gnt_q, gnt_d;
    logic [1:0]          sel_q, sel_d;
    logic                busy_q, busy_d;
    logic                preempt_q, preempt_d;
    logic [3:0]          others;
    logic [1:0]          winner;

    // Returns the first set bit of r, scanning from start upward and wrapping at 3.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] res;
        res = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) res = idx;
        end
        return res;
    endfunction

    assign others = req & ~gnt_q;

    always_comb begin
        // NOTE: every variable gets a default value first, so no path through this block can infer a latch.
        state_d   = state_q;
        last_d    = last_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        winner    = pick(others, sel_q + 2'd1);

        unique case (state_q)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (req != '0) begin
                    winner  = pick(req, last_q + 2'd1);
                    gnt_d   = 4'b0001 << winner;
                    sel_d   = winner;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    last_d = sel_q;
                    hold_d = '0;
                    if (others != '0) begin
                        gnt_d = 4'b0001 << winner;
                        sel_d = winner;
                    end else begin
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (hold_q == HOLD_W'(HOLD_MAX - 1)) begin
                    hold_d = '0;
                    // When nobody else is waiting, the owner keeps the grant and starts a fresh tenure.
                    if (others != '0) begin
                        last_d    = sel_q;
                        gnt_d     = 4'b0001 << winner;
                        sel_d     = winner;
                        preempt_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every register updates from values sampled before the edge.
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 2'd3;
            hold_q    <= '0;
            gnt_q     <= '0;
            sel_q     <= 2'd0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_busy_gnt    : assert property (@(posedge clk) disable iff (!rst_n) busy_q == (gnt_q != '0));
    a_sel_match   : assert property (@(posedge clk) disable iff (!rst_n)
                                     !busy_q || (gnt_q == (4'b0001 << sel_q)));
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus random request traffic,
// all checked against a tenure-counting reference model.
module tb_mux4_rr_arbiter;
    localparam int HM = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;

    int passed = 0;
    int total  = 0;

    // Reference model state: owner index (-1 when idle) and the number of cycles held so far.
    int         m_owner = -1;
    int         m_last  = 3;
    int         m_ten   = 0;
    int         m_sel   = 0;
    logic       m_pre   = 1'b0;

    mux4_rr_arbiter #(.HOLD_MAX(HM)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passed++;
    endtask

    function automatic int next_after(input logic [3:0] r, input int after);
        for (int k = 1; k <= 4; k++) begin
            if (r[(after + k) % 4]) return (after + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_update(input logic [3:0] r, input logic rn);
        logic [3:0] oth;
        m_pre = 1'b0;
        if (!rn) begin
            m_owner = -1; m_last = 3; m_ten = 0; m_sel = 0;
        end else if (m_owner < 0) begin
            if (r != 0) begin
                m_owner = next_after(r, m_last);
                m_ten = 1;
            end
        end else begin
            oth = r & ~(4'b0001 << m_owner);
            if (!r[m_owner]) begin
                m_last = m_owner;
                m_owner = next_after(oth, m_owner);
                m_ten = (m_owner >= 0) ? 1 : 0;
            end else if (m_ten == HM) begin
                if (oth != 0) begin
                    m_last = m_owner;
                    m_owner = next_after(oth, m_owner);
                    m_pre = 1'b1;
                end
                m_ten = 1;
            end else begin
                m_ten++;
            end
        end
        if (m_owner >= 0) m_sel = m_owner;
    endtask

    // Advance one clock, update the model with the inputs seen at the edge, then compare.
    task automatic step();
        logic [3:0] r;
        logic       rn;
        r  = req;
        rn = rst_n;
        @(posedge clk);
        #1;
        model_update(r, rn);
        check("gnt",     32'(gnt),     (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        check("sel",     32'(sel),     32'(m_sel));
        check("busy",    32'(busy),    32'(m_owner >= 0));
        check("preempt", 32'(preempt), 32'(m_pre));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int pre_seen;

        // Reset held for two cycles with every request active.
        rst_n = 1'b0;
        req   = 4'hF;
        step();
        step();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        step();
        check("first_gnt", 32'(gnt), 32'h1);
        check("first_sel", 32'(sel), 32'h0);

        // A single request is granted, then dropped.
        req = 4'b0000;
        do_reset();
        req = 4'b0100;
        step();
        check("single_gnt", 32'(gnt), 32'h4);
        check("single_sel", 32'(sel), 32'h2);
        check("single_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        step();
        check("drop_gnt", 32'(gnt), 32'h0);
        check("drop_busy", 32'(busy), 32'h0);
        check("drop_sel", 32'(sel), 32'h2);

        // Fairness: all four requesters active, each owner releases after two cycles.
        do_reset();
        req = 4'hF;
        step();
        for (int k = 0; k < 5; k++) begin
            check("fair_owner", 32'(gnt), 32'd1 << (k % 4));
            step();
            req = 4'hF & ~(4'b0001 << (k % 4));
            step();
            check("fair_handoff", 32'(gnt), 32'd1 << ((k + 1) % 4));
            check("fair_nobubble", 32'(busy), 32'h1);
            req = 4'hF;
        end

        // Preemption: two requesters held constant for two full tenures.
        req = 4'b0000;
        do_reset();
        req = 4'b0011;
        pre_seen = 0;
        for (int c = 1; c <= 17; c++) begin
            step();
            pre_seen += int'(preempt);
            if (c == 8)  check("pre_hold0", 32'(gnt), 32'h1);
            if (c == 9)  check("pre_rot1", 32'(gnt), 32'h2);
            if (c == 9)  check("pre_pulse", 32'(preempt), 32'h1);
            if (c == 16) check("pre_hold1", 32'(gnt), 32'h2);
            if (c == 17) check("pre_back0", 32'(gnt), 32'h1);
        end
        check("pre_count", 32'(pre_seen), 32'd2);

        // Lone hog: a single requester is never preempted.
        req = 4'b0000;
        do_reset();
        req = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            step();
            check("hog_gnt", 32'(gnt), 32'h8);
            check("hog_nopre", 32'(preempt), 32'h0);
        end

        // Reset mid-grant: priority restarts at requester 0.
        req = 4'b0000;
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 6; c++) step();
        rst_n = 1'b0;
        req = 4'b0110;
        step();
        check("midrst_gnt", 32'(gnt), 32'h0);
        rst_n = 1'b1;
        step();
        check("midrst_win", 32'(gnt), 32'h2);

        // Random traffic: request bits toggle occasionally, with rare resets.
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            end
            rst_n = ($urandom_range(0, 80) != 0);
            step();
        end
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
